// File: rtl/mips_pkg.sv
// Shared definitions for the memory stage: MEM/WB bundle layout, access size
// encodings, controller states and store lane helpers.
package mips_pkg;

    localparam int BUNDLE_W = 103;
    localparam int ALU_LSB  = 71;
    localparam int MEM_LSB  = 39;
    localparam int PC_LSB   = 7;
    localparam int RD_LSB   = 2;
    localparam int RW_BIT   = 1;
    localparam int M2R_BIT  = 0;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [BUNDLE_W-1:0] BUBBLE = {BUNDLE_W{1'b0}};

    function automatic logic [BUNDLE_W-1:0] pack_bundle(
        input logic [31:0] alu,
        input logic [31:0] md,
        input logic [31:0] pc,
        input logic [4:0]  rd,
        input logic        rw,
        input logic        m2r
    );
        logic [BUNDLE_W-1:0] b;
        b = BUBBLE;
        b[ALU_LSB +: 32] = alu;
        b[MEM_LSB +: 32] = md;
        b[PC_LSB  +: 32] = pc;
        b[RD_LSB  +: 5]  = rd;
        b[RW_BIT]        = rw;
        b[M2R_BIT]       = m2r;
        return b;
    endfunction

    // Little-endian byte enables for a store of the given size at addr[1:0].
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 4'b0001 << lo;
            SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] sd);
        case (size)
            SZ_BYTE: return {4{sd[7:0]}};
            SZ_HALF: return {2{sd[15:0]}};
            SZ_WORD: return sd;
            default: return sd;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_load_formatter.sv
// Load data formatter: selects the addressed byte/half lane of the read word
// and sign- or zero-extends it to 32 bits.
module load_formatter
    import mips_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_mem_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection and extension.
    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            2'b11:   w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_size)
            SZ_BYTE: o_mem_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_mem_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_mem_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller feeding the MEM/WB register; runs loads/stores on a
// req/ack port and stalls upstream while busy. Optional abort: MEM_TIMEOUT_EN.
module mem_stage_ctrl
    import mips_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic                in_mem_read,
    input  logic                in_mem_write,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic [31:0]         in_alu_result,
    input  logic [31:0]         in_store_data,
    input  logic [31:0]         in_pc_plus4,
    input  logic [4:0]          in_rd,
    input  logic                in_reg_write,
    input  logic                in_mem_to_reg,
    output logic                stall,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [3:0]          dmem_be,
    output logic [31:0]         dmem_wdata,
    input  logic                dmem_ack,
    input  logic [31:0]         dmem_rdata,
    output logic [BUNDLE_W-1:0] wb_bundle,
    output logic                wb_ld,
    output logic                misalign_err,
    output logic                bus_err
);

    state_t      r_state;
    logic [31:0] r_alu_result;
    logic [31:0] r_pc_plus4;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic        r_mem_to_reg;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;

    logic        w_mem_op;
    logic        w_misalign;
    logic        w_accept;
    logic        w_expire;
    logic [31:0] w_load_data;

    assign w_mem_op   = in_mem_read | in_mem_write;
    assign w_misalign = (in_size == SZ_HALF) ? in_alu_result[0] :
                        (in_size == SZ_BYTE) ? 1'b0 : (in_alu_result[1:0] != 2'b00);
    assign w_accept   = in_valid & w_mem_op & ~w_misalign;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_to_cnt;

    // Expiry is the BUSY cycle that would bring the no-ack count to the limit.
    assign w_expire = (r_state == BUSY) & ~dmem_ack & (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err  = w_expire;

    // No-ack cycle counter, restarted on each accepted access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (w_accept && r_state == IDLE) begin
            r_to_cnt <= '0;
        end else if (r_state == BUSY && !dmem_ack) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= r_to_cnt;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_expire         = 1'b0;
    assign bus_err          = 1'b0;
`endif

    load_formatter u_load_formatter (
        .i_rdata    (dmem_rdata),
        .i_addr_lo  (r_alu_result[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_mem_data (w_load_data)
    );

    assign wb_ld      = ~reset;
    assign dmem_req   = (r_state == BUSY);
    assign dmem_we    = (r_state == BUSY) & r_we;
    assign dmem_addr  = {r_alu_result[ADDR_W-1:2], 2'b00};
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;

    // FSM and latched copy of the accepted memory instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_alu_result <= 32'h0000_0000;
            r_pc_plus4   <= 32'h0000_0000;
            r_rd         <= 5'd0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_we         <= 1'b0;
            r_be         <= 4'b0000;
            r_wdata      <= 32'h0000_0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state      <= BUSY;
                        r_alu_result <= in_alu_result;
                        r_pc_plus4   <= in_pc_plus4;
                        r_rd         <= in_rd;
                        r_reg_write  <= in_reg_write;
                        r_mem_to_reg <= in_mem_to_reg;
                        r_size       <= in_size;
                        r_unsigned   <= in_unsigned;
                        r_we         <= in_mem_write;
                        r_be         <= store_be(in_size, in_alu_result[1:0]);
                        r_wdata      <= store_wdata(in_size, in_store_data);
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY: begin
                    if (dmem_ack || w_expire) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= BUSY;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // MEM/WB bundle, stall and misalign pulse; reset forces a quiet bubble.
    always_comb begin
        wb_bundle    = BUBBLE;
        stall        = 1'b0;
        misalign_err = 1'b0;
        if (reset) begin
            wb_bundle = BUBBLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!in_valid) begin
                        wb_bundle = BUBBLE;
                    end else if (!w_mem_op) begin
                        wb_bundle = pack_bundle(in_alu_result, 32'h0000_0000, in_pc_plus4,
                                                in_rd, in_reg_write, in_mem_to_reg);
                    end else if (w_misalign) begin
                        misalign_err = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        wb_bundle = pack_bundle(r_alu_result, r_we ? 32'h0000_0000 : w_load_data,
                                                r_pc_plus4, r_rd, r_reg_write & ~r_we, r_mem_to_reg);
                    end else if (w_expire) begin
                        stall = 1'b0;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: wb_bundle = BUBBLE;
            endcase
        end
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller; the producer side of the 103-bit MEM/WB pipeline register. It drives that register's datain and LD each cycle.
- Takes decoded EX/MEM fields and performs loads/stores on a req/ack data-memory port.
- Formats load data and emits the assembled MEM/WB bundle.
- Raises a stall to the upstream pipeline while a memory access is outstanding.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- TIMEOUT_CYCLES, 64, BUSY cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high; clears the FSM and all registered outputs.
- in_valid  input  1  EX/MEM holds a real instruction.
- in_mem_read  input  1  load.
- in_mem_write  input  1  store.
- in_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- in_unsigned  input  1  zero-extend loads.
- in_alu_result  input  32  effective address / ALU result.
- in_store_data  input  32  rt value for stores.
- in_pc_plus4  input  32  carried to WB (jal link).
- in_rd  input  5  destination register.
- in_reg_write  input  1  WB writes the register file.
- in_mem_to_reg  input  1  WB selects memory data.
- stall  output  1  hold EX/MEM and earlier stages.
- dmem_req  output  1  access request; held until ack.
- dmem_we  output  1  store.
- dmem_addr  output  ADDR_W  word-aligned address (addr[1:0]=0).
- dmem_be  output  4  byte enables.
- dmem_wdata  output  32  lane-replicated store data.
- dmem_ack  input  1  access complete; rdata valid this cycle.
- dmem_rdata  input  32  read word.
- wb_bundle  output  103  MEM/WB datain.
- wb_ld  output  1  MEM/WB LD.
- misalign_err  output  1  one-cycle pulse.
- bus_err  output  1  one-cycle pulse; tied 0 without MEM_TIMEOUT_EN.

Behaviour:
- Bundle layout: [102:71] alu_result, [70:39] mem_data, [38:7] pc_plus4, [6:2] rd, [1] reg_write, [0] mem_to_reg.
- Bubble = all-zero bundle.
- wb_ld is 1 every cycle outside reset. Stall cycles present a bubble, so WB never sees a repeated write.
- FSM states: IDLE, BUSY. Reset → IDLE, dmem_req=0, all error pulses 0.
- IDLE, in_valid=0: bubble, stall=0.
- IDLE, non-memory op: bundle built combinationally from inputs, mem_data=0, stall=0. Latency 0; MEM/WB captures it at the next edge.
- IDLE, memory op, misaligned (half with addr[0]=1; word with addr[1:0]≠0):
  - no dmem access; misalign_err=1 this cycle; bubble; stall=0.
- IDLE, aligned memory op:
  - latch rd, reg_write, mem_to_reg, pc_plus4, alu_result, size, unsigned, addr[1:0], and we=in_mem_write;
  - stall=1, bubble, go BUSY.
- BUSY: dmem_req=1 and dmem_addr/be/wdata/we driven from latched registers only, stable until ack. stall=1, bubble.
- BUSY with dmem_ack=1:
  - stall=0; wb_ld with the real bundle; next state IDLE;
  - load: mem_data = formatted dmem_rdata;
  - store: reg_write forced 0.
- Minimum memory-op latency: 2 cycles (accept + one BUSY cycle with ack).
- Byte lanes are little-endian.
  - Byte: lane addr[1:0]; be=0001<<addr[1:0]; wdata = {4{sd[7:0]}}.
  - Half: lane addr[1]; be=0011 or 1100; wdata = {2{sd[15:0]}}.
  - Word: be=1111.
- Load extension: sign-extend from bit 7/15 unless unsigned.
- dmem_ack in IDLE is ignored.
- in_* changes during BUSY are ignored; only the latched copy is used.
- Async reset mid-BUSY: dmem_req drops immediately, transaction abandoned, no bundle emitted.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: a counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: dmem_req drops, bus_err=1 for one cycle, bubble, stall=0, go IDLE.
  - Ack in the same cycle as expiry wins (normal completion).
- Undefined: no counter; BUSY waits indefinitely; bus_err tied 0.

Decomposition:
- Package mips_pkg:
  - bundle width and field offset constants;
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum {IDLE, BUSY};
  - BUBBLE constant.
- One combinational sub-module, load_formatter: inputs rdata, addr[1:0], size, unsigned; output 32-bit mem_data.

Test Plan:
- ALU op alu=0x00000010, rd=5, reg_write=1 → same cycle wb_bundle[102:71]=0x10, rd=5, stall=0, no dmem_req.
- lb addr=0x103, rdata=0x80FF1234, ack on first BUSY cycle:
  - stall high for exactly 1 cycle, dmem_addr=0x100;
  - mem_data=0xFFFFFF80; lbu variant gives 0x00000080.
- sh addr=0x102, sd=0x0000BEEF, ack after 3 BUSY cycles:
  - be=1100, wdata=0xBEEFBEEF held stable all 3 cycles;
  - bundle reg_write=0; 3 bubbles precede it.
- lw addr=0x202 → misalign_err pulse, no dmem_req, bubble, stall=0. Back-to-back lw addr=0x204 then accepted normally.
- Async reset asserted mid-BUSY → dmem_req and stall fall without a clock edge; after release, FSM is in IDLE and outputs bubbles.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → bus_err pulses in the 4th BUSY cycle, req drops, next instruction proceeds.
